// File: rtl/nes_joypad_port.sv
// NES $4016/$4017 joypad register emulation fed by an SNES controller reader.
// Resynchronises and filters the SNES button vector, remaps it (with turbo), and serialises it.
module nes_joypad_port #(
  parameter int TURBO_PERIOD  = 833333,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] BUTTONS,
  input  logic        TURBO_EN,
  input  logic        CPU_WR,
  input  logic        CPU_WDATA,
  input  logic        CPU_RD,
  output logic [7:0]  RDATA,
  output logic [7:0]  PRESSED,
  output logic [3:0]  SHIFT_COUNT
);

  localparam int CNT_W = (TURBO_PERIOD > 2) ? $clog2(TURBO_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURBO_PERIOD - 1);
  localparam logic [9:0] IDLE_RAW = ACTIVE_LOW_IN ? 10'h3FF : 10'h000;

  // L, R and the ID nibble never reach the NES side.
  logic unused_bits;
  assign unused_bits = ^BUTTONS[15:10];

  logic [9:0]       sync1_reg, sync2_reg, filt_reg, sample_norm;
  logic [CNT_W-1:0] turbo_cnt_reg;
  logic             phase_reg;
  logic [7:0]       pressed_reg, pressed_next;
  logic [7:0]       shift_reg, shift_next;
  logic [3:0]       count_reg, count_next;
  logic             strobe_reg, strobe_next;
  logic             rdata_reg, rdata_next;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_norm
      assign sample_norm[gi] = sync2_reg[gi] ^ ACTIVE_LOW_IN;
    end
  endgenerate

  // Filter only accepts a vector once two back-to-back samples agree, hiding reader skew.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync1_reg <= IDLE_RAW;
      sync2_reg <= IDLE_RAW;
      filt_reg  <= '0;
    end else begin
      sync1_reg <= BUTTONS[9:0];
      sync2_reg <= sync1_reg;
      if (sync1_reg == sync2_reg)
        filt_reg <= sample_norm;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      turbo_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (turbo_cnt_reg == CNT_LAST) begin
      turbo_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      turbo_cnt_reg <= turbo_cnt_reg + 1'b1;
    end
  end

  // SNES order {X,A,R..L..} -> NES order A,B,Select,Start,Up,Down,Left,Right.
  always_comb begin
    pressed_next    = filt_reg[7:0];
    pressed_next[0] = filt_reg[8] | (TURBO_EN & filt_reg[9] & phase_reg);
    pressed_next[1] = filt_reg[0] | (TURBO_EN & filt_reg[1] & phase_reg);
  end

  always_comb begin
    strobe_next = strobe_reg;
    shift_next  = shift_reg;
    count_next  = count_reg;
    rdata_next  = rdata_reg;
    if (CPU_RD)
      rdata_next = strobe_reg ? pressed_reg[0] : shift_reg[0];
    if (strobe_reg) begin
      shift_next = pressed_reg;
      count_next = 4'd0;
    end else if (CPU_RD) begin
      shift_next = {1'b1, shift_reg[7:1]};
      if (count_reg != 4'd8)
        count_next = count_reg + 4'd1;
    end
    if (CPU_WR) begin
      strobe_next = CPU_WDATA;
      if (CPU_WDATA)
        count_next = 4'd0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pressed_reg <= '0;
      shift_reg   <= 8'hFF;
      count_reg   <= 4'd0;
      strobe_reg  <= 1'b0;
      rdata_reg   <= 1'b0;
    end else begin
      pressed_reg <= pressed_next;
      shift_reg   <= shift_next;
      count_reg   <= count_next;
      strobe_reg  <= strobe_next;
      rdata_reg   <= rdata_next;
    end
  end

  assign RDATA       = {7'b0, rdata_reg};
  assign PRESSED     = pressed_reg;
  assign SHIFT_COUNT = count_reg;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Bench for nes_joypad_port: directed test-plan sequences plus randomized traffic,
// all compared every cycle against a behavioural joypad model.
module tb_nes_joypad_port;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] buttons = 16'hFFFF;
  logic        turbo_en = 1'b0;
  logic        wr = 1'b0, wdata = 1'b0, rd = 1'b0;
  logic [7:0]  rdata, pressed;
  logic [3:0]  shift_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  nes_joypad_port #(.TURBO_PERIOD(P), .ACTIVE_LOW_IN(1'b1)) dut (
    .CLOCK(clk), .RESET(rst), .BUTTONS(buttons), .TURBO_EN(turbo_en),
    .CPU_WR(wr), .CPU_WDATA(wdata), .CPU_RD(rd),
    .RDATA(rdata), .PRESSED(pressed), .SHIFT_COUNT(shift_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: state after each clock edge.
  logic [15:0] b1, b2;        // BUTTONS seen at the previous two edges
  logic [9:0]  m_filt;        // active-high, SNES bit order
  logic [7:0]  m_pressed, m_snap;
  int          m_idx, m_edges;
  logic        m_strobe, m_rdata;
  bit          started = 0;

  function automatic logic [7:0] nes_of(input logic [9:0] f, input logic t, input logic ph);
    logic [7:0] r;
    r = {f[7], f[6], f[5], f[4], f[3], f[2], 1'b0, 1'b0};
    r[0] = f[8] | (t & f[9] & ph);
    r[1] = f[0] | (t & f[1] & ph);
    return r;
  endfunction

  initial forever begin
    logic [7:0] np;
    logic [9:0] nf;
    @(posedge clk);
    if (rst) begin
      b1 = 16'hFFFF; b2 = 16'hFFFF; m_filt = '0; m_pressed = '0;
      m_snap = 8'hFF; m_idx = 0; m_edges = 0; m_strobe = 0; m_rdata = 0;
      started = 1;
    end else begin
      np = nes_of(m_filt, turbo_en, 1'((m_edges / P) % 2));
      nf = (b1[9:0] == b2[9:0]) ? ~b2[9:0] : m_filt;
      if (rd) begin
        if (m_strobe) m_rdata = m_pressed[0];
        else begin
          m_rdata = (m_idx < 8) ? m_snap[m_idx] : 1'b1;
          if (m_idx < 8) m_idx++;
        end
      end
      if (m_strobe) begin m_snap = m_pressed; m_idx = 0; end
      if (wr) begin
        m_strobe = wdata;
        if (wdata) m_idx = 0;
      end
      b2 = b1; b1 = buttons; m_filt = nf; m_pressed = np; m_edges++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("rdata", rdata, {7'b0, m_rdata});
      check("pressed", pressed, m_pressed);
      check("shift_count", {4'b0, shift_count}, 8'(m_idx));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic cpu_write(input logic v);
    @(negedge clk); wr = 1'b1; wdata = v;
    @(negedge clk); wr = 1'b0;
  endtask
  task automatic cpu_read(output logic b);
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    b = rdata[0];
  endtask

  initial begin
    logic       b;
    logic [7:0] seq;
    logic [15:0] ph;
    cyc(2);
    rst = 1'b0;
    check("reset_pressed", pressed, 8'h00);
    check("reset_rdata", rdata, 8'h00);
    check("reset_count", {4'b0, shift_count}, 8'h00);
    cyc(5);
    check("idle_pressed", pressed, 8'h00);
    cpu_read(b);
    check("idle_read", rdata, 8'h01);

    // B and A pressed
    buttons = 16'hFEFE; cyc(6);
    check("ab_pressed", pressed, 8'h03);
    cpu_write(1'b1); cpu_write(1'b0);
    for (int i = 0; i < 10; i++) begin
      cpu_read(b);
      check($sformatf("ab_read%0d", i), {7'b0, b}, (i < 2 || i >= 8) ? 8'h01 : 8'h00);
    end
    check("ab_count_sat", {4'b0, shift_count}, 8'h08);

    // strobe held high, Start only
    cpu_write(1'b1);
    buttons = 16'hFFF7; cyc(6);
    check("start_pressed", pressed, 8'h08);
    for (int i = 0; i < 3; i++) begin
      cpu_read(b);
      check("strobe_read", {7'b0, b}, 8'h00);
      check("strobe_count", {4'b0, shift_count}, 8'h00);
    end

    // latch Up, release before reading
    buttons = 16'hFFEF; cyc(6);
    cpu_write(1'b1); cpu_write(1'b0);
    buttons = 16'hFFFF; cyc(6);
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      cpu_read(b);
      seq[i] = b;
    end
    check("up_snapshot", seq, 8'h10);

    // turbo: X pressed, A released
    turbo_en = 1'b1; buttons = 16'hFDFF; cyc(6);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); ph[i] = pressed[0];
    end
    for (int i = 4; i < 16; i++)
      check("turbo_toggle", {7'b0, ph[i] ^ ph[i-4]}, 8'h01);
    check("turbo_duty", 8'($countones(ph)), 8'd8);
    turbo_en = 1'b0; cyc(2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("turbo_off", {7'b0, pressed[0]}, 8'h00);
    end

    // simultaneous read and strobe write after latching A
    buttons = 16'hFEFF; cyc(6);
    cpu_write(1'b1); cpu_write(1'b0);
    @(negedge clk); rd = 1'b1; wr = 1'b1; wdata = 1'b1;
    @(negedge clk); rd = 1'b0; wr = 1'b0;
    check("rdwr_rdata", rdata, 8'h01);
    check("rdwr_count", {4'b0, shift_count}, 8'h00);

    // reset in the middle of a read sequence
    buttons = 16'hFFFF; cyc(6);
    cpu_write(1'b0);
    for (int i = 0; i < 3; i++) cpu_read(b);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_count", {4'b0, shift_count}, 8'h00);
    cpu_read(b);
    check("rst_read", rdata, 8'h01);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0: buttons = 16'($urandom);
        1: buttons = buttons ^ (16'h1 << $urandom_range(0, 15));
        default: ;
      endcase
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 7) == 0);
      wdata = 1'($urandom);
      if ($urandom_range(0, 63) == 0) turbo_en = ~turbo_en;
      rst = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk); rd = 1'b0; wr = 1'b0; rst = 1'b0;
    cyc(3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/nes_joypad_port.md
Name: nes_joypad_port

Overview:
- Downstream consumer of the SNES controller reader's 16-bit BUTTONS vector; emulates the NES CPU-visible joypad register ($4016 strobe write, $4016/$4017 serial read).
- Resynchronises and filters the button vector, which is produced in the slow SNES clock domain.
- Remaps SNES buttons to NES order, with optional turbo on X/Y.
- Presents the standard NES 8-bit serial shift protocol to the CPU bus logic.

Parameters:
- TURBO_PERIOD, 833333, system-clock cycles per turbo phase toggle (about 30 Hz full cycle at 50 MHz); must be at least 2.
- ACTIVE_LOW_IN, 1, 1 means BUTTONS bit = 0 is pressed (SNES native); 0 means BUTTONS bit = 1 is pressed.

Ports:
- CLOCK  input  1  system clock (CLOCK_50 domain).
- RESET  input  1  synchronous, active-high reset.
- BUTTONS  input  16  raw SNES vector from the reader, asynchronous to CLOCK. Bit map: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 15:12 ID.
- TURBO_EN  input  1  enables X→turbo-A and Y→turbo-B.
- CPU_WR  input  1  one-cycle pulse: CPU write to $4016.
- CPU_WDATA  input  1  bit 0 of the write data (strobe).
- CPU_RD  input  1  one-cycle pulse: CPU read of this port.
- RDATA  output  8  read data; bit 0 is the serial bit, bits 7:1 are 0.
- PRESSED  output  8  filtered NES-order button state, active-high (A,B,Sel,Start,U,D,L,R in bits 0..7).
- SHIFT_COUNT  output  4  reads since strobe fell, saturating at 8.

Behaviour:
- Reset (RESET=1 at a CLOCK edge): RDATA=0, PRESSED=0, SHIFT_COUNT=0, strobe=0, shift reg=8'hFF, sync/filter regs = "not pressed", turbo counter=0, turbo phase=0. Reset mid-read-sequence aborts it; the next read returns 1 until strobe is pulsed.
- Input sync and filter:
  - Each BUTTONS bit passes through a 2-flop synchroniser.
  - The filtered vector updates only when two consecutive synchronised samples are identical. This rejects the multi-bit skew while the reader updates bits one at a time.
  - Latency: a stable input change appears on PRESSED in 4 cycles.
  - Polarity is normalised to active-high per ACTIVE_LOW_IN.
- Remap:
  - NES A = SNES A | (TURBO_EN & X & phase).
  - NES B = SNES B | (TURBO_EN & Y & phase).
  - Select, Start, Up, Down, Left, Right map directly.
  - L, R and ID bits are ignored.
  - PRESSED is registered: 1 cycle after the filtered/turbo value changes.
- Turbo:
  - The counter counts 0..TURBO_PERIOD-1, then wraps and phase toggles.
  - It runs regardless of TURBO_EN.
- Strobe: CPU_WR loads strobe <= CPU_WDATA.
- While strobe=1:
  - The shift reg reloads with PRESSED every cycle, and SHIFT_COUNT=0.
  - A read returns PRESSED[0] (A) and does not shift.
- Falling edge (strobe 1→0 on a write): the shift reg holds the value loaded on the last strobe=1 cycle; no further reloads.
- Read with strobe=0:
  - RDATA[0] <= shift[0].
  - Shift reg <= {1'b1, shift[7:1]}.
  - SHIFT_COUNT increments, saturating at 8.
  - After 8 reads, every read returns 1.
- RDATA timing: registered, valid the cycle after CPU_RD, held until the next CPU_RD.
- Simultaneous CPU_RD and CPU_WR in one cycle: the read uses the pre-write strobe and shift state; the write takes effect for the next cycle.
- CPU_WR with the same strobe value: 1→1 keeps reloading; 0→0 does not reload or reset SHIFT_COUNT.
- CPU_RD held high for multiple cycles counts one read per high cycle.

Test Plan:
- Reset, then BUTTONS=16'hFFFF (nothing pressed) → PRESSED=8'h00; read with strobe=0 returns RDATA=8'h01 (shift reg 8'hFF).
- BUTTONS=16'hFEFE (SNES B and A pressed), wait 6 cycles, write 1, write 0, read 10 times → RDATA[0] sequence 1,1,0,0,0,0,0,0,1,1; SHIFT_COUNT ends at 8.
- Strobe held at 1, press Start only, read 3 times → each read returns PRESSED[0]=0; SHIFT_COUNT stays 0.
- Latch with Up pressed, release Up before reading → bit 4 of the read sequence is still 1 (snapshot held).
- TURBO_EN=1, TURBO_PERIOD=4, X pressed, A released → PRESSED[0] toggles every 4 cycles; with TURBO_EN=0, PRESSED[0]=0 constant.
- CPU_RD and CPU_WR(1) in the same cycle after latching A pressed → RDATA[0]=1 (old shift[0]); the next cycle shows strobe=1 and SHIFT_COUNT=0. Separately, RESET asserted after 3 reads → the next read returns 1.
